// File: rtl/led_bank_arbiter_if.sv
// Requester/arbiter bundle for the shared LED bank.
// Handshake: each requester holds req high for as long as it wants the bank. gnt (one-hot or zero) marks the owner, and the owner keeps the bank until its slice expires or it drops req.
interface led_bank_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 16
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]    req;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]    gnt;
  logic [DW-1:0]       led;
  logic                owner_valid;
  logic [IW-1:0]       owner_id;
  logic                slice_done;
  logic                arb_state;

  modport master (
    output req, req_data,
    input  gnt, led, owner_valid, owner_id, slice_done, arb_state
  );
  modport slave (
    input  req, req_data,
    output gnt, led, owner_valid, owner_id, slice_done, arb_state
  );
endinterface

// File: rtl/led_bank_arbiter.sv
// Time-sliced round-robin owner of the LED bank; each owner keeps it for 2**LOG2HOLD clocks or until release.
// Optional macro LED_BANK_ARBITER_PREEMPT_EN: requester 0 preempts any other owner.
module led_bank_arbiter #(
  parameter int N_REQ    = 4,
  parameter int DW       = 16,
  parameter int LOG2HOLD = 22,
  parameter logic [DW-1:0] IDLE_PATTERN = '0
) (
  input  logic clk,
  input  logic rst_n,
  led_bank_arbiter_if.slave bus
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

  state_t              state;
  logic [IW-1:0]       ptr;
  logic [IW-1:0]       owner;
  logic [IW-1:0]       next_ptr;
  logic [LOG2HOLD-1:0] cnt;
  logic                owner_req;
  logic [DW-1:0]       owner_data;
  logic                found_ptr, found_next;
  logic [IW-1:0]       win_ptr, win_next;

  // First set request scanning start, start+1, ... (mod N_REQ); MSB flags a hit.
  function automatic logic [IW:0] pick(input logic [N_REQ-1:0] r, input logic [IW-1:0] start);
    logic [IW:0] res;
    int          idx;
    res = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(start) + k) % N_REQ;
      if (r[idx]) res = {1'b1, IW'(idx)};
    end
    return res;
  endfunction

  always_comb begin
    owner_req  = 1'b0;
    owner_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner == IW'(i)) begin
        owner_req  = bus.req[i];
        owner_data = bus.req_data[i*DW +: DW];
      end
    end
    next_ptr = (owner == IW'(N_REQ - 1)) ? '0 : owner + IW'(1);
    {found_ptr, win_ptr}   = pick(bus.req, ptr);
    {found_next, win_next} = pick(bus.req, next_ptr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      ptr             <= '0;
      owner           <= '0;
      cnt             <= '0;
      bus.gnt         <= '0;
      bus.led         <= IDLE_PATTERN;
      bus.owner_valid <= 1'b0;
      bus.slice_done  <= 1'b0;
    end else begin
      bus.slice_done <= 1'b0;
      case (state)
        IDLE: begin
          bus.led <= IDLE_PATTERN;
          if (found_ptr) begin
            state           <= OWN;
            owner           <= win_ptr;
            bus.gnt         <= N_REQ'(1) << win_ptr;
            bus.owner_valid <= 1'b1;
            cnt             <= '0;
          end
        end
        OWN: begin
          bus.led <= owner_data;
          if (!owner_req) begin
            // Release beats timeout: hand off without a pulse, or fall back to idle.
            ptr <= next_ptr;
            cnt <= '0;
            if (found_next) begin
              owner   <= win_next;
              bus.gnt <= N_REQ'(1) << win_next;
            end else begin
              state           <= IDLE;
              owner           <= '0;
              bus.gnt         <= '0;
              bus.owner_valid <= 1'b0;
              bus.led         <= IDLE_PATTERN;
            end
          end
`ifdef LED_BANK_ARBITER_PREEMPT_EN
          else if (owner != '0 && bus.req[0]) begin
            owner   <= '0;
            bus.gnt <= N_REQ'(1);
            cnt     <= '0;
          end
`endif
          else if (cnt == '1) begin
            // Owner still requesting, so win_next always finds a winner (possibly itself).
            bus.slice_done <= 1'b1;
            ptr            <= next_ptr;
            owner          <= win_next;
            bus.gnt        <= N_REQ'(1) << win_next;
            cnt            <= '0;
          end else begin
            cnt <= cnt + LOG2HOLD'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.owner_id  = owner;
  assign bus.arb_state = (state == OWN);
endmodule

// File: tb/tb_led_bank_arbiter.sv
// Bench for led_bank_arbiter: directed scenarios plus random requests, checked every cycle against an ownership model.
module tb_led_bank_arbiter;
  localparam int N     = 4;
  localparam int DW    = 16;
  localparam int LH    = 3;
  localparam int SLICE = 1 << LH;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N*DW-1:0] req_data = '0;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Model state: who owns the bank, how long they have held it, and the rotation start.
  int            m_owner = -1;
  int            m_age   = 0;
  int            m_ptr   = 0;
  logic [DW-1:0] m_led   = '0;
  bit            m_done  = 1'b0;

  led_bank_arbiter_if #(.N_REQ(N), .DW(DW)) bus ();
  assign bus.req      = req;
  assign bus.req_data = req_data;

  led_bank_arbiter #(
    .N_REQ(N), .DW(DW), .LOG2HOLD(LH), .IDLE_PATTERN(16'h0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++)
      if (r[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  function automatic logic [DW-1:0] data_of(input int i);
    return req_data[i*DW +: DW];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1; m_age = 0; m_ptr = 0; m_led = '0; m_done = 1'b0;
    end else begin : model_step
      int o;
      o      = m_owner;
      m_done = 1'b0;
      if (o < 0) begin
        m_led   = 16'h0000;
        m_owner = pick(req, m_ptr);
        m_age   = 0;
      end else if (!req[o]) begin
        m_ptr   = (o + 1) % N;
        m_owner = pick(req, m_ptr);
        m_led   = (m_owner >= 0) ? data_of(o) : 16'h0000;
        m_age   = 0;
      end
`ifdef LED_BANK_ARBITER_PREEMPT_EN
      else if (o != 0 && req[0]) begin
        m_led = data_of(o); m_owner = 0; m_age = 0;
      end
`endif
      else if (m_age == SLICE - 1) begin
        m_done  = 1'b1;
        m_ptr   = (o + 1) % N;
        m_owner = pick(req, m_ptr);
        m_led   = data_of(o);
        m_age   = 0;
      end else begin
        m_led = data_of(o);
        m_age++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("gnt", bus.gnt, (m_owner < 0) ? 32'd0 : 32'(1 << m_owner));
      check("led", bus.led, m_led);
      check("owner_valid", bus.owner_valid, m_owner >= 0);
      check("owner_id", bus.owner_id, (m_owner < 0) ? 32'd0 : 32'(m_owner));
      check("slice_done", bus.slice_done, m_done);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_data(input int i, input logic [DW-1:0] v);
    req_data[i*DW +: DW] = v;
  endtask

  initial begin : main
    int dones;
    int led_bad;
    req_data = {$urandom, $urandom};
    cyc(2);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Reset values and idle with no requests.
    check("rst_gnt", bus.gnt, 0);
    check("rst_led", bus.led, 16'h0000);
    check("rst_valid", bus.owner_valid, 0);
    check("rst_done", bus.slice_done, 0);
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.slice_done) dones++;
    end
    check("idle_led", bus.led, 16'h0000);
    check("idle_dones", dones, 0);

    // Two requesters alternate on timeout.
    set_data(0, 16'h00AA);
    set_data(2, 16'h5500);
    req = 4'b0101;
    cyc(1);
    check("alt_first_gnt", bus.gnt, 4'b0001);
    check("alt_first_led", bus.led, 16'h0000);
    cyc(8);
    check("alt_swap_gnt", bus.gnt, 4'b0100);
    check("alt_swap_done", bus.slice_done, 1);
    cyc(1);
    check("alt_swap_led", bus.led, 16'h5500);
    check("alt_done_1cyc", bus.slice_done, 0);
    cyc(7);
    check("alt_back_gnt", bus.gnt, 4'b0001);
    check("alt_back_done", bus.slice_done, 1);
    cyc(64);

    // Sole requester is re-granted to itself without an idle glitch.
    set_data(3, 16'hF00F);
    req = 4'b1000;
    cyc(2);
    check("sole_gnt", bus.gnt, 4'b1000);
    dones = 0; led_bad = 0;
    repeat (24) begin
      @(negedge clk);
      if (bus.slice_done) dones++;
      if (bus.led !== 16'hF00F) led_bad++;
    end
    check("sole_dones", dones, 3);
    check("sole_led_glitches", led_bad, 0);

    // Early release hands off without a pulse, then release to idle.
    req = 4'b0000;
    cyc(2);
    check("rel_idle_gnt", bus.gnt, 0);
    req = 4'b0011;
    cyc(1);
    check("rel_first_gnt", bus.gnt, 4'b0001);
    cyc(3);
    req = 4'b0010;
    cyc(1);
    check("rel_hand_gnt", bus.gnt, 4'b0010);
    check("rel_hand_done", bus.slice_done, 0);
    cyc(7);
    check("rel_fresh_nodone", bus.slice_done, 0);
    cyc(1);
    check("rel_fresh_done", bus.slice_done, 1);
    req = 4'b0000;
    cyc(1);
    check("rel_end_gnt", bus.gnt, 0);
    check("rel_end_led", bus.led, 16'h0000);
    check("rel_end_valid", bus.owner_valid, 0);

    // Asynchronous reset mid-slice, then rotation restarts at requester 0.
    req = 4'b0100;
    cyc(1);
    check("rst_pre_gnt", bus.gnt, 4'b0100);
    cyc(5);
    #2 rst_n = 1'b0;
    #1;
    check("arst_gnt", bus.gnt, 0);
    check("arst_led", bus.led, 16'h0000);
    check("arst_valid", bus.owner_valid, 0);
    check("arst_id", bus.owner_id, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    req = 4'b1111;
    cyc(1);
    check("arst_first_gnt", bus.gnt, 4'b0001);

    // Requester 0 arriving mid-slice.
    req = 4'b0100;
    cyc(1);
    check("pre_owner_gnt", bus.gnt, 4'b0100);
    cyc(2);
    req = 4'b0101;
    cyc(1);
`ifdef LED_BANK_ARBITER_PREEMPT_EN
    check("pre_gnt", bus.gnt, 4'b0001);
`else
    check("pre_gnt", bus.gnt, 4'b0100);
`endif
    check("pre_done", bus.slice_done, 0);
    cyc(20);

    // Random requests and data.
    repeat (400) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) req = N'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) req_data = {$urandom, $urandom};
    end
    cyc(2);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
